// File: rtl/mandelbrot_seq_if.sv
// rtl/mandelbrot_seq_if.sv - point request, core drive and result signals of the Mandelbrot sequencer
interface mandelbrot_seq_if #(
  parameter int ITER_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_cr;
  logic [31:0]       in_ci;
  logic [ITER_W-1:0] in_max_iter;
  logic              acc_start;
  logic              acc_load_cr;
  logic              acc_load_ci;
  logic [7:0]        acc_data;
  logic              acc_unbounded;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;

  modport slave (
    input  in_valid, in_cr, in_ci, in_max_iter, acc_unbounded, out_ready,
    output in_ready, acc_start, acc_load_cr, acc_load_ci, acc_data,
           out_valid, out_iter, out_escaped
  );

  modport master (
    output in_valid, in_cr, in_ci, in_max_iter, acc_unbounded, out_ready,
    input  in_ready, acc_start, acc_load_cr, acc_load_ci, acc_data,
           out_valid, out_iter, out_escaped
  );
endinterface

// File: rtl/mandelbrot_seq.sv
// rtl/mandelbrot_seq.sv - loads one point into the Mandelbrot core byte-serially and counts its iterations
module mandelbrot_seq #(
  parameter int ITER_W = 8
) (
  input  logic clk,
  input  logic rst,
  mandelbrot_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CR,
    S_LOAD_CI,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       cr_q, cr_d;
  logic [31:0]       ci_q, ci_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic [ITER_W-1:0] count_q, count_d;
  logic [ITER_W-1:0] count_inc;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [ITER_W-1:0] out_iter_q, out_iter_d;
  logic              out_escaped_q, out_escaped_d;
  logic              acc_start_q, acc_start_d;
  logic              acc_load_cr_q, acc_load_cr_d;
  logic              acc_load_ci_q, acc_load_ci_d;
  logic [7:0]        acc_data_q, acc_data_d;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    max_d         = max_q;
    count_d       = count_q;
    out_iter_d    = out_iter_q;
    out_escaped_d = out_escaped_q;
    count_inc     = count_q + ITER_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          cr_d    = bus.in_cr;
          ci_d    = bus.in_ci;
          max_d   = bus.in_max_iter;
          idx_d   = 2'd0;
          state_d = S_LOAD_CR;
        end
      end
      S_LOAD_CR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_LOAD_CI;
        end
      end
      S_LOAD_CI: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_START;
        end
      end
      S_START: begin
        count_d = '0;
        if (max_q == '0) begin
          state_d       = S_DONE;
          out_iter_d    = '0;
          out_escaped_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Escape wins over the limit when both land on the same cycle.
        if (bus.acc_unbounded) begin
          state_d       = S_DONE;
          out_iter_d    = count_q;
          out_escaped_d = 1'b1;
        end else if (count_inc == max_q) begin
          state_d       = S_DONE;
          out_iter_d    = max_q;
          out_escaped_d = 1'b0;
        end else begin
          count_d = count_inc;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they appear registered.
    in_ready_d    = (state_d == S_IDLE);
    out_valid_d   = (state_d == S_DONE);
    acc_start_d   = (state_d == S_START);
    acc_load_cr_d = (state_d == S_LOAD_CR) && (idx_d == 2'd3);
    acc_load_ci_d = (state_d == S_LOAD_CI) && (idx_d == 2'd3);
    acc_data_d    = 8'h00;
    if (state_d == S_LOAD_CR) begin
      acc_data_d = byte_sel(cr_d, idx_d);
    end else if (state_d == S_LOAD_CI) begin
      acc_data_d = byte_sel(ci_d, idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      cr_q          <= '0;
      ci_q          <= '0;
      max_q         <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_iter_q    <= '0;
      out_escaped_q <= 1'b0;
      acc_start_q   <= 1'b0;
      acc_load_cr_q <= 1'b0;
      acc_load_ci_q <= 1'b0;
      acc_data_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      max_q         <= max_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_iter_q    <= out_iter_d;
      out_escaped_q <= out_escaped_d;
      acc_start_q   <= acc_start_d;
      acc_load_cr_q <= acc_load_cr_d;
      acc_load_ci_q <= acc_load_ci_d;
      acc_data_q    <= acc_data_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_iter    = out_iter_q;
  assign bus.out_escaped = out_escaped_q;
  assign bus.acc_start   = acc_start_q;
  assign bus.acc_load_cr = acc_load_cr_q;
  assign bus.acc_load_ci = acc_load_ci_q;
  assign bus.acc_data    = acc_data_q;

endmodule
